// File: rtl/dig_stopwatch_mc.sv
// Multi-channel AXI4-Lite stopwatch: NUM_CH up-counters sharing one prescaler, with lap capture
// and sticky wrap flags. Define DIG_STOPWATCH_IRQ_EN to add the IRQ_MASK register and irq output.
module dig_stopwatch_mc #(
    parameter int NUM_CH             = 4,
    parameter int COUNT_W            = 32,
    parameter int PRESC_W            = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
`ifdef DIG_STOPWATCH_IRQ_EN
    ,
    output logic                            irq
`endif
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1'b1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1'b1);
    localparam logic [NUM_CH-1:0]  CH_ZERO    = {NUM_CH{1'b0}};

    logic              awready_r, bvalid_r, arready_r, rvalid_r;
    logic [DW-1:0]     rdata_r, rd_data_s;
    logic [NUM_CH-1:0] run_r, wrap_r, wrap_nxt_s, clr_s, lap_s;
    logic [PRESC_W-1:0] presc_r, pcnt_r;
    logic [COUNT_W-1:0] count_r [NUM_CH];
    logic [COUNT_W-1:0] lap_r [NUM_CH];
    logic [31:0]       wr_word_s, rd_word_s;
    logic              wr_fire_s, rd_fire_s, tick_s;
    logic              wr_run_s, wr_cmd_s, wr_presc_s, wr_status_s;
    logic              unused_s;

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = awready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = 2'b00;

    assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr[1:0],
                        s_axi_araddr[1:0], s_axi_wdata};

    assign wr_word_s   = 32'(s_axi_awaddr[AW-1:2]);
    assign rd_word_s   = 32'(s_axi_araddr[AW-1:2]);
    assign wr_fire_s   = awready_r && s_axi_awvalid && s_axi_wvalid;
    assign rd_fire_s   = arready_r && s_axi_arvalid;
    assign wr_run_s    = wr_fire_s && (wr_word_s == 32'd0);
    assign wr_cmd_s    = wr_fire_s && (wr_word_s == 32'd1);
    assign wr_presc_s  = wr_fire_s && (wr_word_s == 32'd2);
    assign wr_status_s = wr_fire_s && (wr_word_s == 32'd3);
    assign clr_s       = wr_cmd_s ? s_axi_wdata[NUM_CH-1:0] : CH_ZERO;
    assign lap_s       = wr_cmd_s ? s_axi_wdata[16 +: NUM_CH] : CH_ZERO;
    assign tick_s      = (pcnt_r == presc_r);

    // AXI handshake: single-cycle ready pulses, valids held until the master accepts
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DW{1'b0}};
        end else begin
            awready_r <= s_axi_awvalid && s_axi_wvalid && !bvalid_r && !awready_r;
            arready_r <= s_axi_arvalid && !rvalid_r && !arready_r;
            if (wr_fire_s) begin
                bvalid_r <= 1'b1;
            end else if (bvalid_r && s_axi_bready) begin
                bvalid_r <= 1'b0;
            end
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
            end else if (rvalid_r && s_axi_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Wrap flags: clear first, then a fresh wrap, and only then software W1C
    always_comb begin
        wrap_nxt_s = wrap_r;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clr_s[c]) begin
                wrap_nxt_s[c] = 1'b0;
            end else if (tick_s && run_r[c] && (count_r[c] == CNT_MAX)) begin
                wrap_nxt_s[c] = 1'b1;
            end else if (wr_status_s && s_axi_wdata[c]) begin
                wrap_nxt_s[c] = 1'b0;
            end else begin
                wrap_nxt_s[c] = wrap_r[c];
            end
        end
    end

    // Control registers and the shared prescaler; a PRESCALE write restarts the phase
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run_r   <= CH_ZERO;
            wrap_r  <= CH_ZERO;
            presc_r <= PRESC_ZERO;
            pcnt_r  <= PRESC_ZERO;
        end else begin
            wrap_r <= wrap_nxt_s;
            if (wr_run_s) begin
                run_r <= s_axi_wdata[NUM_CH-1:0];
            end
            if (wr_presc_s) begin
                presc_r <= s_axi_wdata[PRESC_W-1:0];
                pcnt_r  <= PRESC_ZERO;
            end else if (tick_s) begin
                pcnt_r <= PRESC_ZERO;
            end else begin
                pcnt_r <= pcnt_r + PRESC_ONE;
            end
        end
    end

    // Channel counters and lap snapshots; lap captures the pre-increment count
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                count_r[c] <= CNT_ZERO;
                lap_r[c]   <= CNT_ZERO;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr_s[c]) begin
                    count_r[c] <= CNT_ZERO;
                    lap_r[c]   <= CNT_ZERO;
                end else begin
                    if (lap_s[c]) begin
                        lap_r[c] <= count_r[c];
                    end
                    if (tick_s && run_r[c]) begin
                        count_r[c] <= count_r[c] + CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef DIG_STOPWATCH_IRQ_EN
    logic [NUM_CH-1:0] mask_r;
    logic              irq_r;
    logic              wr_mask_s;

    assign wr_mask_s = wr_fire_s && (wr_word_s == 32'd4);
    assign irq       = irq_r;

    // Interrupt mask and registered level interrupt
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mask_r <= CH_ZERO;
            irq_r  <= 1'b0;
        end else begin
            irq_r <= |(wrap_r & mask_r);
            if (wr_mask_s) begin
                mask_r <= s_axi_wdata[NUM_CH-1:0];
            end
        end
    end
`endif

    // Read decode; channel windows start at word 8, COUNT on even words and LAP on odd
    always_comb begin
        rd_data_s = {DW{1'b0}};
        case (rd_word_s)
            32'd0:   rd_data_s = DW'(run_r);
            32'd2:   rd_data_s = DW'(presc_r);
            32'd3:   rd_data_s = DW'(wrap_r);
`ifdef DIG_STOPWATCH_IRQ_EN
            32'd4:   rd_data_s = DW'(mask_r);
`endif
            default: rd_data_s = {DW{1'b0}};
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            rd_data_s = rd_data_s
                      | ((rd_word_s == 32'(8 + 2 * c)) ? DW'(count_r[c]) : {DW{1'b0}})
                      | ((rd_word_s == 32'(9 + 2 * c)) ? DW'(lap_r[c])   : {DW{1'b0}});
        end
    end

endmodule
